tx_serial_param: RTL
====================

# tx_serial_param

Parametrised asynchronous serial transmitter. It supersedes the fixed-format 7E1 transmitter and is configurable at elaboration time:
- 5–9 data bits
- parity none, even or odd
- 1 or 2 stop bits
- any baud divisor

It sits between a character source (controller FSM or test front-end) and a GPIO serial output pin. One clock domain, no external tick generator.

## Interface
Parameters:
- CLK_DIV, 434, clock cycles per serial bit (434 = 115200 baud at 50 MHz); legal ≥ 2
- DATA_BITS, 7, data bits per frame; legal 5..9
- PARITY, 1, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, legal 1 or 2

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- partida  in  1  start request, level-sampled in IDLE
- dados  in  DATA_BITS  character to send, captured at accepted start
- saida_serial  out  1  serial line, idle high
- pronto  out  1  one-cycle pulse at end of frame
- ocupado  out  1  high while a frame is on the line
- db_estado  out  4  current FSM state code

## Operation
- Frame length is N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bits.
- Frame order: start (0), data LSB first, parity if enabled, stop bit(s) (1).
- Parity:
  - even = XOR of captured data bits
  - odd = inverted XOR of captured data bits
- States and db_estado codes:
  - IDLE 4'h0: line 1, ocupado 0. partida = 1 at an edge → SEND. On that same edge:
    - load the frame shift register
    - clear the baud counter and bit counter
  - SEND 4'h2: line = shift register LSB, ocupado 1.
    - Baud counter counts 0..CLK_DIV-1; tick when count = CLK_DIV-1.
    - On tick: shift right with fill 1, increment bit counter.
    - Tick with bit counter = N-1 → DONE.
  - DONE 4'hF: line 1, ocupado 0, pronto 1. Unconditionally → IDLE next edge.
  - Any other code → IDLE (illegal-state recovery).
- partida is ignored in SEND and DONE. dados changes after capture do not affect the frame.
- If partida is held high continuously, frames repeat, separated by DONE + IDLE (2 idle-high cycles).
- Widths:
  - baud counter: $clog2(CLK_DIV) bits
  - bit counter: $clog2(N+1) bits
  - shift register: N bits
- No counter wraps mid-frame; the baud counter restarts at 0 on each tick.
- Reset (asynchronous, any state, including mid-bit):
  - state IDLE
  - saida_serial 1, pronto 0, ocupado 0, db_estado 4'h0
  - counters 0, shift register all 1
- Outputs are driven from registers or directly decoded from the registered state; no combinational path from partida or dados to outputs.

## Timing
- Let E0 be the edge that samples partida = 1 in IDLE.
- Start bit (0) is on the line from E0 to E0 + CLK_DIV cycles.
- Frame bit k (k = 0..N-1) occupies edges E0 + k·CLK_DIV to E0 + (k+1)·CLK_DIV, exactly CLK_DIV cycles each.
- ocupado is high from E0 until E0 + N·CLK_DIV.
- pronto is high for exactly one cycle, E0 + N·CLK_DIV to E0 + N·CLK_DIV + 1.
- Earliest next accepted start: edge E0 + N·CLK_DIV + 2 (the first edge in IDLE); its start bit begins there.
- Latency from accepted partida to line low: 1 edge. No bit-length jitter.

## Test plan
- Reset response: assert reset asynchronously between edges.
  - Required: saida_serial = 1, pronto = 0, ocupado = 0, db_estado = 0 immediately, with no clock.
- Default 7E1 frame (CLK_DIV = 4), dados = 7'h41, 1-cycle partida.
  - Line: 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles.
  - pronto pulses at E0 + 40 for 1 cycle; ocupado high for 40 cycles.
- 8O2 frame (CLK_DIV = 4, DATA_BITS = 8, PARITY = 2, STOP_BITS = 2), dados = 8'h55.
  - Line: 0,1,0,1,0,1,0,1,0,1,1,1 (odd parity bit 1).
  - pronto at E0 + 48.
- 5N1 frame (DATA_BITS = 5, PARITY = 0, CLK_DIV = 3), dados = 5'h1F.
  - Line: 0,1,1,1,1,1,1 (7 bits, 21 cycles); pronto at E0 + 21.
- Start ignored while busy, and back-to-back frames.
  - Pulse partida mid-frame and change dados mid-frame: frame unchanged, no extra pronto.
  - Hold partida high: second start bit begins at E0 + N·CLK_DIV + 2, exactly 2 idle-high cycles between frames.
- Reset mid-frame: assert reset during data bit 3, release, then pulse partida.
  - Line returns to 1 at once; db_estado = 0.
  - The next frame is complete and correct from its own start bit; no residual bits.

Source files
------------

// File: rtl/tx_serial_param.sv
// Parametrised asynchronous serial transmitter.
// Frame: start bit (0), DATA_BITS data bits LSB first, optional even/odd
// parity bit, STOP_BITS stop bits (1). Each bit lasts CLK_DIV clock cycles.
// The whole frame is loaded into a shift register when the start is accepted,
// so later changes on dados cannot disturb a frame already on the line.
module tx_serial_param #(
   parameter int CLK_DIV   = 434,
   parameter int DATA_BITS = 7,
   parameter int PARITY    = 1,
   parameter int STOP_BITS = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 partida,
   input  logic [DATA_BITS-1:0] dados,
   output logic                 saida_serial,
   output logic                 pronto,
   output logic                 ocupado,
   output logic [3:0]           db_estado
);

   localparam int PAR_BITS = (PARITY != 0) ? 1 : 0;
   localparam int N        = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
   localparam int BAUD_W   = $clog2(CLK_DIV);
   localparam int BIT_W    = $clog2(N + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N - 1);

   typedef enum logic [3:0] {
      IDLE = 4'h0,
      SEND = 4'h2,
      DONE = 4'hF
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [N-1:0]      shift_reg;
   logic              tick;
   logic              last_bit;

   // Parity over the captured character; odd parity is the inverted XOR.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
      logic p;
      p = ^d;
      if (PARITY == 2) p = ~p;
      return p;
   endfunction

   // Assemble the complete frame with the start bit in the LSB so that
   // shifting right presents the bits in transmission order. Positions not
   // written here (stop bits) stay at 1.
   function automatic logic [N-1:0] build_frame(input logic [DATA_BITS-1:0] d);
      logic [N-1:0] f;
      f              = '1;
      f[0]           = 1'b0;
      f[DATA_BITS:1] = d;
      if (PARITY != 0) f[DATA_BITS+1] = parity_bit(d);
      return f;
   endfunction

   assign tick     = (baud_cnt == BAUD_LAST);
   assign last_bit = (bit_cnt == BIT_LAST);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state decode; unknown codes fall back to IDLE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (partida) next_state = SEND;
         SEND:    if (tick && last_bit) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Baud counter, bit counter and frame shift register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '1;
      end else begin
         case (state)
            IDLE: begin
               if (partida) begin
                  shift_reg <= build_frame(dados);
                  baud_cnt  <= '0;
                  bit_cnt   <= '0;
               end
            end
            SEND: begin
               if (tick) begin
                  baud_cnt  <= '0;
                  bit_cnt   <= bit_cnt + 1'b1;
                  shift_reg <= {1'b1, shift_reg[N-1:1]};
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decode only registered state, never partida or dados directly.
   assign saida_serial = (state == SEND) ? shift_reg[0] : 1'b1;
   assign ocupado      = (state == SEND);
   assign pronto       = (state == DONE);
   assign db_estado    = state;

endmodule
